clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//   Measures the period of a slow square wave (e.g. clock_divider slow_clock, external pin)
//   in fast_clock cycles; reports rising-edge-to-rising-edge period, its floor(log2), and a
//   stalled flag when no edge arrives. Feeds 7-segment/LED display logic on the 50 MHz board.
// PARAMETERS
//   CNT_W        28  width of period counter/result; must be > TIMEOUT_POW
//   SYNC_STAGES   2  flip-flops in slow_in synchroniser (>=2)
//   TIMEOUT_POW  27  stall when 2**TIMEOUT_POW-1 cycles pass without a rising edge
// PORTS
//   fast_clock    in   1      system clock (50 MHz)
//   rst_n         in   1      asynchronous active-low reset
//   slow_in       in   1      asynchronous slow signal to measure
//   period        out  CNT_W  last measured period, in fast_clock cycles
//   div_pow       out  5      floor(log2(period)); 2**N divider output gives N
//   period_valid  out  1      one-cycle pulse when period/div_pow update
//   stalled       out  1      high: no valid measurement / timeout occurred
// BEHAVIOUR
//   Reset (async assert, sync-release irrelevant here): period=0, div_pow=0, period_valid=0,
//     stalled=1, sync chain=0, counter=0, state=IDLE.
//   Input path: SYNC_STAGES-flop synchroniser, then 1 delay flop; rise = sync & ~dly.
//     Latency slow_in rise -> rise detected: SYNC_STAGES+1 cycles.
//   FSM (2 states):
//     IDLE:    counter held 0. On rise -> MEASURE, counter<=1. No period_valid.
//     MEASURE: counter<=counter+1 each cycle without rise.
//              On rise: period<=counter, div_pow<=msb index of counter, period_valid<=1
//              (visible next cycle), stalled<=0, counter<=1, stay MEASURE.
//              If counter==2**TIMEOUT_POW-1 and no rise: stalled<=1, -> IDLE, counter<=0;
//              period/div_pow hold old values, no period_valid.
//   Result: square wave of P cycles -> period==P exactly (rise-to-rise, duty irrelevant).
//   Boundaries:
//     rise on same cycle as timeout count: rise wins (measurement, no stall).
//     P=1 unreachable through synchroniser; minimum reportable P=2 (alternating samples).
//     counter never wraps: timeout precedes overflow since TIMEOUT_POW < CNT_W.
//     div_pow for period 0 (reset only) =0; computed by priority encoder, width 5.
//     period_valid never asserted two consecutive cycles.
//     rst_n asserted mid-measurement: all state cleared immediately, next rise restarts IDLE path
//       (first post-reset rise yields no measurement; second rise yields first period_valid).
//   stalled deasserts only on a completed measurement, never on first rise alone.
// STRUCTURE
//   clock_meter_pkg: typedef enum logic {IDLE, MEASURE} meter_state_t; localparam DIV_POW_W=5;
//     function msb_index(logic [CNT_W-1:0]) shared with display logic.
//   Sub-module sync_rise_detect (#(SYNC_STAGES)): fast_clock, rst_n, async_in -> rise pulse.
//   Top holds FSM, counter, result registers, priority encoder.
// TESTING (bench uses TIMEOUT_POW=10, CNT_W=12, SYNC_STAGES=2)
//   1. Square wave period 64 (32 hi/32 lo) -> from 2nd rise on: period=64, div_pow=6,
//      period_valid pulses every 64 cycles, stalled 1->0 at first pulse.
//   2. Duty 10/54 (P=64) -> period=64 identical to test 1; then switch to P=256 ->
//      first post-switch valid shows 256, div_pow=8.
//   3. Hold slow_in low after P=64 run -> stalled=1 exactly 1023 cycles after last rise
//      counter started; period stays 64; next two rises restore period_valid.
//   4. Rise arriving on exact timeout cycle (P=1023) -> period=1023, div_pow=9, stalled stays 0.
//   5. Fastest input (toggle every sampled cycle, P=2) -> period=2, div_pow=1, no missed pulses.
//   6. Drop rst_n mid-measurement (counter ~30) -> outputs reset values same cycle;
//      after release, first rise no pulse, second rise gives correct period.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared types and helpers for the clock period meter and the display logic that consumes it.
package clock_meter_pkg;

    typedef enum logic {
        IDLE,
        MEASURE
    } meter_state_t;

    localparam int DIV_POW_W = 5;
    localparam int MAX_CNT_W = 32;

    // Priority encoder: index of the highest set bit, 0 for a zero value.
    function automatic logic [DIV_POW_W-1:0] msb_index(input logic [MAX_CNT_W-1:0] value);
        logic [DIV_POW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CNT_W; i++) begin
            if (value[i]) begin
                idx = i[DIV_POW_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an asynchronous signal into the fast_clock domain and flags its rising edges.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic fast_clock,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_dly;

    always_ff @(posedge fast_clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
            sync_dly   <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
            sync_dly   <= sync_chain[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse on the first synchronised high sample after a low one.
    assign rise = sync_chain[SYNC_STAGES-1] & ~sync_dly;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the rise-to-rise period of a slow signal in fast_clock cycles, with
// floor(log2) of the result and a stall flag when edges stop arriving.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_POW = 27
) (
    input  logic                 fast_clock,
    input  logic                 rst_n,
    input  logic                 slow_in,
    output logic [CNT_W-1:0]     period,
    output logic [DIV_POW_W-1:0] div_pow,
    output logic                 period_valid,
    output logic                 stalled
);

    localparam logic [CNT_W-1:0] TIMEOUT_COUNT =
        {{(CNT_W - TIMEOUT_POW){1'b0}}, {TIMEOUT_POW{1'b1}}};

    logic         rise;
    meter_state_t state;
    logic [CNT_W-1:0] counter;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_rise_detect (
        .fast_clock(fast_clock),
        .rst_n     (rst_n),
        .async_in  (slow_in),
        .rise      (rise)
    );

    // A rise that lands on the timeout count still completes a measurement,
    // so the rise branch is checked before the timeout compare.
    always_ff @(posedge fast_clock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            period       <= '0;
            div_pow      <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b1;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEASURE;
                        counter <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        counter <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period       <= counter;
                        div_pow      <= msb_index(MAX_CNT_W'(counter));
                        period_valid <= 1'b1;
                        stalled      <= 1'b0;
                        counter      <= {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (counter == TIMEOUT_COUNT) begin
                        stalled <= 1'b1;
                        state   <= IDLE;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: expected periods are queued from the
// stimulus timing and popped whenever the DUT pulses period_valid.
module tb_clock_period_meter;

    localparam int CNT_W       = 12;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_POW = 10;
    localparam int TIMEOUT     = (1 << TIMEOUT_POW) - 1;

    logic             fast_clock;
    logic             rst_n;
    logic             slow_in;
    logic [CNT_W-1:0] period;
    logic [4:0]       div_pow;
    logic             period_valid;
    logic             stalled;

    int checkCount = 0;
    int errorCount = 0;
    int expectQ[$];
    bit haveRise   = 0;
    int gapCycles  = 0;
    logic slowLevel = 1'b0;
    logic prevValid = 1'b0;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_POW(TIMEOUT_POW)
    ) dut (
        .fast_clock  (fast_clock),
        .rst_n       (rst_n),
        .slow_in     (slow_in),
        .period      (period),
        .div_pow     (div_pow),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    initial fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    function automatic int floorLog2(input int value);
        int r = 0;
        int v = value;
        while (v > 1) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive a level for a number of cycles; a low-to-high change closes the model's gap.
    task automatic applyStimulus(input logic level, input int cycles);
        if (level && !slowLevel) begin
            if (haveRise && gapCycles <= TIMEOUT) begin
                expectQ.push_back(gapCycles);
            end
            haveRise  = 1'b1;
            gapCycles = 0;
        end
        slow_in   = level;
        slowLevel = level;
        repeat (cycles) @(posedge fast_clock);
        #1;
        gapCycles += cycles;
    endtask

    task automatic squareWave(input int hi, input int lo, input int count);
        for (int n = 0; n < count; n++) begin
            applyStimulus(1'b1, hi);
            applyStimulus(1'b0, lo);
        end
    endtask

    // Scoreboard consumer, sampled on the falling edge.
    initial begin
        int exp;
        forever begin
            @(negedge fast_clock);
            checkOutput("valid_back_to_back", int'(period_valid & prevValid), 0);
            prevValid = period_valid;
            if (period_valid) begin
                if (expectQ.size() == 0) begin
                    checkOutput("unexpected_valid", period, -1);
                end else begin
                    exp = expectQ.pop_front();
                    checkOutput("period", period, exp);
                    checkOutput("div_pow", div_pow, floorLog2(exp));
                    checkOutput("stalled_at_valid", stalled, 0);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        slow_in = 1'b0;
        repeat (3) @(posedge fast_clock);
        #1;
        checkOutput("reset_period", period, 0);
        checkOutput("reset_div_pow", div_pow, 0);
        checkOutput("reset_valid", period_valid, 0);
        checkOutput("reset_stalled", stalled, 1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 5);

        // Test 1: 32/32 square wave; stalled stays high until the first measurement.
        applyStimulus(1'b1, 32);
        applyStimulus(1'b0, 32);
        checkOutput("t1_stalled_first_rise", stalled, 1);
        squareWave(32, 32, 5);

        // Test 2: skewed duty at the same period, then a slower 256-cycle wave.
        squareWave(10, 54, 4);
        squareWave(128, 128, 3);

        // Test 3: stop after a 64-cycle period and watch the timeout land.
        squareWave(32, 32, 3);
        applyStimulus(1'b1, 32);
        applyStimulus(1'b0, TIMEOUT + 2 - 32);
        checkOutput("t3_not_yet_stalled", stalled, 0);
        applyStimulus(1'b0, 1);
        checkOutput("t3_stalled", stalled, 1);
        checkOutput("t3_period_held", period, 64);
        checkOutput("t3_div_pow_held", div_pow, 6);
        applyStimulus(1'b0, 50);
        applyStimulus(1'b1, 32);
        applyStimulus(1'b0, 32);
        checkOutput("t3_stalled_after_one_rise", stalled, 1);
        squareWave(32, 32, 2);
        checkOutput("t3_recovered", stalled, 0);

        // Test 4: rise on the exact timeout count wins over the stall.
        squareWave(500, TIMEOUT - 500, 3);

        // Test 5: fastest reportable input, also ending the last 1023-cycle period.
        squareWave(1, 1, 20);
        checkOutput("t5_stalled", stalled, 0);

        // Test 6: reset in the middle of a measurement.
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 20);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_period", period, 0);
        checkOutput("t6_reset_div_pow", div_pow, 0);
        checkOutput("t6_reset_stalled", stalled, 1);
        checkOutput("t6_reset_valid", period_valid, 0);
        repeat (3) @(posedge fast_clock);
        #1;
        rst_n     = 1'b1;
        haveRise  = 1'b0;
        gapCycles = 0;
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 30);
        checkOutput("t6_no_pulse_first_rise", stalled, 1);
        squareWave(25, 25, 3);
        applyStimulus(1'b0, 20);

        checkOutput("scoreboard_drained", expectQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
